data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, meaning RAM size in bytes (power of two).
REQ-002 SHALL have parameter TX_DEPTH, default 8, meaning TX FIFO entries (power of two, max 8).
REQ-003 i_clk  input  1  sole clock; all state updates on posedge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_mem_addr  input  32  byte address from the execute unit.
REQ-006 i_mem_write  input  1  1 = write the byte at i_mem_addr this cycle.
REQ-007 i_mem_data  input  `DATA_WIDTH  write data byte.
REQ-008 o_mem_data  output  `DATA_WIDTH  read data byte, combinational from i_mem_addr.
REQ-009 o_tx_data  output  8  head byte of the TX FIFO.
REQ-010 o_tx_valid  output  1  TX FIFO not empty.
REQ-011 i_tx_ready  input  1  consumer accepts the head byte when high with o_tx_valid.
REQ-012 o_err  output  1  sticky unmapped-access flag.

Function
REQ-013 Map: 0x0000_0000..DEPTH-1 RAM; 0xFFFF_FF00 TXDATA; 0xFFFF_FF01 STATUS; 0xFFFF_FF04..07 CYCLE bytes 0..3 (little-endian).
REQ-014 RAM read SHALL be asynchronous (same-cycle o_mem_data); RAM write SHALL occur at posedge when i_mem_write=1.
REQ-015 Read-after-write to the same RAM byte SHALL return the new value from the cycle after the write.
REQ-016 TXDATA write SHALL push i_mem_data when count<TX_DEPTH, or when count==TX_DEPTH and a pop occurs in the same cycle; TXDATA read returns 0.
REQ-017 Pop SHALL occur at posedge when o_tx_valid and i_tx_ready; simultaneous push and pop leave count unchanged.
REQ-018 Push while full without a same-cycle pop SHALL be dropped and SHALL set sticky STATUS[2] (overflow).
REQ-019 STATUS read: [0] full, [1] empty, [2] overflow, [3] 0, [7:4] count (0..TX_DEPTH).
REQ-020 Any STATUS write SHALL clear overflow; other STATUS bits are read-only.
REQ-021 FIFO read/write pointers SHALL wrap modulo TX_DEPTH.
REQ-022 CYCLE counter SHALL be 32 bits, increment every non-reset cycle, wrap 0xFFFF_FFFF->0.
REQ-023 Read of CYCLE byte 0 SHALL return live counter[7:0] and, at that posedge, latch counter[31:8] into a shadow; byte 1..3 reads return the shadow bytes.
REQ-024 Any CYCLE-byte write SHALL clear the counter to 0 at that posedge (write wins over increment).
REQ-025 Unmapped MMIO addresses in 0xFFFF_FF00..FF reads SHALL return 0; writes SHALL be ignored.

Reset
REQ-026 On i_rst: FIFO empty (o_tx_valid=0, o_tx_data=0), count 0, overflow 0, counter 0, shadow 0, o_err 0.
REQ-027 RAM contents SHALL NOT be reset; o_mem_data follows REQ-014 during reset.
REQ-028 Reset mid-burst SHALL discard all FIFO entries; a push asserted in the reset cycle is dropped.

Configuration
REQ-029 Macro DATA_MEM_BOUNDS_CHECK_EN defined: non-RAM, non-MMIO addresses SHALL read 0, ignore writes, and set o_err sticky until reset.
REQ-030 DATA_MEM_BOUNDS_CHECK_EN undefined: non-MMIO addresses SHALL alias into RAM modulo DEPTH; o_err tied 0.

Verification
REQ-031 Write 0xA5 to 0x10, next cycle read 0x10 -> o_mem_data=0xA5; bytes 0x11..0x13 unaffected.
REQ-032 With i_tx_ready=0, push 9 bytes 0x01..0x09 to TXDATA -> STATUS=0x85 (count 8, full, overflow); then i_tx_ready=1 -> o_tx_data 0x01..0x08 in order, then STATUS=0x06.
REQ-033 FIFO full, push 0x55 and pop same cycle -> count stays 8, 0x55 emerges last, overflow stays 0.
REQ-034 After reset run 300 cycles, read CYCLE byte 0 then bytes 1..3 over next cycles -> assembled value equals counter at byte-0 read (e.g. 0x0000012C); write CYCLE byte 2 -> next read of byte 0 small (<4).
REQ-035 With DATA_MEM_BOUNDS_CHECK_EN, write 0x77 to 0x0001_0000 -> o_err=1 next cycle, RAM byte 0x0 unchanged; without it, same write -> byte 0x0 reads 0x77, o_err=0.
REQ-036 Push 3 bytes then assert i_rst one cycle -> o_tx_valid=0, STATUS=0x02, o_err=0.

Source files
------------

// File: rtl/data_mem_if.sv
// Execute-unit memory bus and TX byte stream for data_mem.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface data_mem_if;
  logic [31:0]            i_mem_addr;
  logic                   i_mem_write;
  logic [`DATA_WIDTH-1:0] i_mem_data;
  logic [`DATA_WIDTH-1:0] o_mem_data;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;
  logic                   o_err;

  modport master (
    output i_mem_addr, i_mem_write, i_mem_data, i_tx_ready,
    input  o_mem_data, o_tx_data, o_tx_valid, o_err
  );

  modport slave (
    input  i_mem_addr, i_mem_write, i_mem_data, i_tx_ready,
    output o_mem_data, o_tx_data, o_tx_valid, o_err
  );
endinterface

// File: rtl/data_mem.sv
// Byte-wide data RAM with MMIO TX FIFO, STATUS and CYCLE counter at 0xFFFF_FFxx.
// DATA_MEM_BOUNDS_CHECK_EN: out-of-range addresses read 0, drop writes, set sticky o_err.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module data_mem #(
  parameter int DEPTH    = 4096,
  parameter int TX_DEPTH = 8
) (
  input logic       i_clk,
  input logic       i_rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;

  logic [7:0]    ram  [DEPTH];
  logic [7:0]    fifo [TX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count;
  logic          overflow;
  logic [31:0]   cycle;
  logic [23:0]   shadow;

  logic          is_mmio, ram_hit;
  logic          sel_tx, sel_stat, sel_cyc;
  logic [AW-1:0] ram_idx;
  logic          push_req, push_ok, pop, full, empty;
  logic [7:0]    status, mmio_rd;

  assign is_mmio = (bus.i_mem_addr[31:8] == 24'hFF_FFFF);
  assign ram_idx = bus.i_mem_addr[AW-1:0];

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  logic oob;
  logic err;

  assign ram_hit = !is_mmio && (bus.i_mem_addr[31:AW] == '0);
  assign oob     = !is_mmio && !ram_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst)    err <= 1'b0;
    else if (oob) err <= 1'b1;
  end

  assign bus.o_err = err;
`else
  // Without bounds checking the upper address bits simply alias into RAM.
  assign ram_hit   = !is_mmio;
  assign bus.o_err = 1'b0;
`endif

  assign sel_tx   = is_mmio && (bus.i_mem_addr[7:0] == 8'h00);
  assign sel_stat = is_mmio && (bus.i_mem_addr[7:0] == 8'h01);
  assign sel_cyc  = is_mmio && (bus.i_mem_addr[7:2] == 6'b000001);

  assign full     = (count == 4'(TX_DEPTH));
  assign empty    = (count == 4'd0);
  assign pop      = !empty && bus.i_tx_ready;
  assign push_req = bus.i_mem_write && sel_tx;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign status   = {count, 1'b0, overflow, empty, full};

  always_comb begin
    mmio_rd = 8'h00;
    if (sel_stat) begin
      mmio_rd = status;
    end else if (sel_cyc) begin
      case (bus.i_mem_addr[1:0])
        2'd0:    mmio_rd = cycle[7:0];
        2'd1:    mmio_rd = shadow[7:0];
        2'd2:    mmio_rd = shadow[15:8];
        default: mmio_rd = shadow[23:16];
      endcase
    end
  end

  assign bus.o_mem_data = ram_hit ? ram[ram_idx] : mmio_rd;
  assign bus.o_tx_valid = !empty;
  assign bus.o_tx_data  = empty ? 8'h00 : fifo[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (bus.i_mem_write && ram_hit) ram[ram_idx] <= bus.i_mem_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && push_ok) fifo[wr_ptr] <= bus.i_mem_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (bus.i_mem_write && sel_stat)  overflow <= 1'b0;
      else if (push_req && !push_ok)    overflow <= 1'b1;
    end
  end

  // Reading byte 0 freezes the upper bytes so a multi-cycle read is coherent.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle  <= 32'd0;
      shadow <= 24'd0;
    end else begin
      cycle <= (bus.i_mem_write && sel_cyc) ? 32'd0 : cycle + 32'd1;
      if (!bus.i_mem_write && sel_cyc && bus.i_mem_addr[1:0] == 2'd0)
        shadow <= cycle[31:8];
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: vector table for RAM/MMIO decode plus FIFO, counter and reset sequences.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_data_mem;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  data_mem_if bus ();

  data_mem dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        rdy;
    logic        chk_rd;
    logic [7:0]  exp_rd;
    logic        exp_valid;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set(input logic [31:0] a, input logic w, input logic [7:0] d, input logic r);
    bus.i_mem_addr  = a;
    bus.i_mem_write = w;
    bus.i_mem_data  = d;
    bus.i_tx_ready  = r;
  endtask

  localparam logic [31:0] TXD  = 32'hFFFF_FF00;
  localparam logic [31:0] STAT = 32'hFFFF_FF01;
  localparam logic [31:0] CYC0 = 32'hFFFF_FF04;

  initial begin
    logic [7:0]  b0, b1, b2, b3;
    logic [7:0]  drain_exp [8];

    set(32'h0, 1'b0, 8'h00, 1'b0);
    i_rst = 1'b1;
    step();
    step();
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("rst_valid", bus.o_tx_valid, 1'b0);
    chk("rst_txdata", bus.o_tx_data, 8'h00);
    chk("rst_err", bus.o_err, 1'b0);
    chk("rst_status", bus.o_mem_data, 8'h02);
    i_rst = 1'b0;
    step();

    vecs.push_back('{32'h11, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'h12, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'h13, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'h10, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'h10, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00});
    vecs.push_back('{32'h11, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00});
    vecs.push_back('{32'h12, 1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00});
    vecs.push_back('{32'h13, 1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00});
    vecs.push_back('{32'hFFF, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'hFFF, 1'b0, 8'h00, 1'b0, 1'b1, 8'hEE, 1'b0, 8'h00});
    vecs.push_back('{32'h0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'h0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h00});
    vecs.push_back('{STAT, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00});
    vecs.push_back('{TXD, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'hFFFF_FF03, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'hFFFF_FF03, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{32'hFFFF_FF08, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{TXD, 1'b1, 8'h42, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00});
    vecs.push_back('{STAT, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b1, 8'h42});
    vecs.push_back('{STAT, 1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 1'b1, 8'h42});
    vecs.push_back('{STAT, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00});

    foreach (vecs[i]) begin
      set(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].rdy);
      #1;
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), bus.o_mem_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_valid", i), bus.o_tx_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_tx", i), bus.o_tx_data, vecs[i].exp_tx);
      step();
    end

    // Nine pushes into an 8-deep FIFO with the consumer stalled.
    for (int i = 1; i <= 9; i++) begin
      set(TXD, 1'b1, 8'(i), 1'b0);
      step();
    end
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("ovf_status", bus.o_mem_data, 8'h85);
    set(32'h0, 1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk($sformatf("ovf_drain%0d_valid", i), bus.o_tx_valid, 1'b1);
      chk($sformatf("ovf_drain%0d_data", i), bus.o_tx_data, 8'(i));
      step();
    end
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("ovf_empty_status", bus.o_mem_data, 8'h06);
    set(STAT, 1'b1, 8'hAB, 1'b0);
    step();
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("ovf_cleared", bus.o_mem_data, 8'h02);

    // Full FIFO with a simultaneous push and pop.
    for (int i = 0; i < 8; i++) begin
      set(TXD, 1'b1, 8'h10 + 8'(i), 1'b0);
      step();
    end
    set(TXD, 1'b1, 8'h55, 1'b1);
    #1;
    chk("pp_head", bus.o_tx_data, 8'h10);
    step();
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("pp_status", bus.o_mem_data, 8'h81);
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    set(32'h0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("pp_drain%0d", i), bus.o_tx_data, drain_exp[i]);
      step();
    end
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("pp_final_status", bus.o_mem_data, 8'h02);

    // Reset in the middle of a burst, with a push on the reset cycle itself.
    for (int i = 0; i < 3; i++) begin
      set(TXD, 1'b1, 8'hC0 + 8'(i), 1'b0);
      step();
    end
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("burst_status", bus.o_mem_data, 8'h30);
    set(TXD, 1'b1, 8'h99, 1'b0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    set(STAT, 1'b0, 8'h00, 1'b0);
    #1;
    chk("mid_rst_valid", bus.o_tx_valid, 1'b0);
    chk("mid_rst_txdata", bus.o_tx_data, 8'h00);
    chk("mid_rst_status", bus.o_mem_data, 8'h02);
    chk("mid_rst_err", bus.o_err, 1'b0);

    // Counter is 0 after the reset edge; 300 edges later it reads 0x12C.
    set(32'h0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("ram_kept_over_reset", bus.o_mem_data, 8'h5A);
    repeat (300) step();
    set(CYC0, 1'b0, 8'h00, 1'b0);
    #1;
    b0 = bus.o_mem_data;
    chk("cyc_b0", b0, 8'h2C);
    step();
    set(CYC0 + 32'd1, 1'b0, 8'h00, 1'b0);
    #1;
    b1 = bus.o_mem_data;
    chk("cyc_b1", b1, 8'h01);
    step();
    set(CYC0 + 32'd2, 1'b0, 8'h00, 1'b0);
    #1;
    b2 = bus.o_mem_data;
    step();
    set(CYC0 + 32'd3, 1'b0, 8'h00, 1'b0);
    #1;
    b3 = bus.o_mem_data;
    step();
    chk("cyc_assembled", {b3, b2, b1, b0}, 32'h0000_012C);
    set(CYC0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("cyc_live_b0", bus.o_mem_data, 8'h30);
    set(CYC0 + 32'd2, 1'b1, 8'h00, 1'b0);
    step();
    set(CYC0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("cyc_clr_small", (bus.o_mem_data < 8'd4), 1'b1);
    chk("cyc_clr_exact", bus.o_mem_data, 8'h00);
    step();

    // Address beyond DEPTH: aliases into RAM unless bounds checking is built in.
    set(32'h0001_0000, 1'b1, 8'h77, 1'b0);
    step();
    set(32'h0, 1'b0, 8'h00, 1'b0);
    #1;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    chk("oob_ram0", bus.o_mem_data, 8'h5A);
    chk("oob_err", bus.o_err, 1'b1);
`else
    chk("alias_ram0", bus.o_mem_data, 8'h77);
    chk("alias_err", bus.o_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
